id_rom_lookup_ctrl: RTL and testbench

- Sequences the 8-entry x 16-bit user-ID ROM to search for a candidate ID entered by the player/login logic.
- Issues one ROM address per cycle and accounts for the ROM's fixed read latency.
- Compares returned words against the latched candidate and reports match and matched index via a req/done handshake.
- Sits between the ID-entry front end and ROM_ID; it is the sole driver of the ROM address bus.

---
 rtl/id_rom_pkg.sv | 33 +++
 rtl/id_rom_lookup_ctrl_if.sv | 33 +++
 rtl/rom_rd_pipe.sv | 35 +++
 rtl/id_rom_lookup_ctrl.sv | 169 ++++++++++++++++
 tb/tb_id_rom_lookup_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/id_rom_pkg.sv
// Shared types and constants for the user-ID ROM lookup controller.
//   ID_W     : width of a user ID / ROM word
//   ADDR_W   : width of the ROM address / match index
//   EMPTY_ID : reserved empty-slot value, never a valid match
//   state_t  : lookup FSM states
//   token_t  : in-flight read marker carried alongside the ROM latency
package id_rom_pkg;

  localparam int ID_W   = 16;
  localparam int ADDR_W = 3;
  localparam logic [ID_W-1:0] EMPTY_ID = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] index;
  } token_t;

  // A returned word hits only if its read is live, it equals the candidate,
  // and it is not an empty slot.
  function automatic logic is_hit(input token_t tok,
                                  input logic [ID_W-1:0] q,
                                  input logic [ID_W-1:0] id);
    return tok.valid && (q == id) && (q != EMPTY_ID);
  endfunction

endpackage

// File: rtl/id_rom_lookup_ctrl_if.sv
// Bus bundle between the ID-entry front end / ROM and the lookup controller.
//   req, id_in       : lookup request and candidate ID
//   rom_q            : ROM read data
//   rom_address      : ROM address (driven only by the controller)
//   busy, done       : handshake status
//   match            : lookup result
//   match_index      : index of first matching entry
//   lockout          : lookups disabled after repeated failures
// Modports: slave = controller side, master = front end / ROM side.
interface id_rom_lookup_ctrl_if;
  import id_rom_pkg::*;

  logic              req;
  logic [ID_W-1:0]   id_in;
  logic [ID_W-1:0]   rom_q;
  logic [ADDR_W-1:0] rom_address;
  logic              busy;
  logic              done;
  logic              match;
  logic [ADDR_W-1:0] match_index;
  logic              lockout;

  modport slave (
    input  req, id_in, rom_q,
    output rom_address, busy, done, match, match_index, lockout
  );

  modport master (
    output req, id_in, rom_q,
    input  rom_address, busy, done, match, match_index, lockout
  );

endinterface

// File: rtl/rom_rd_pipe.sv
// Delay line of read tokens matching the ROM read latency, so each returned
// word can be paired with the index that produced it.
//   clk      : system clock
//   rst      : async active-low reset
//   flush    : synchronous clear of all stages
//   push_tok : token entering stage 0
//   pop_tok  : token leaving the last stage
module rom_rd_pipe
  import id_rom_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  token_t push_tok,
  output token_t pop_tok
);

  token_t stage_q [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= push_tok;
      for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign pop_tok = stage_q[STAGES-1];

endmodule

// File: rtl/id_rom_lookup_ctrl.sv
// Searches the user-ID ROM for a latched candidate ID, one address per cycle,
// pairing each returned word with its index through rom_rd_pipe.
//   clk : system clock, rising edge
//   rst : async active-low reset
//   bus : id_rom_lookup_ctrl_if.slave (req/id_in/rom_q in; rom_address,
//         busy, done, match, match_index, lockout out)
// Optional build macro ID_ROM_LOOKUP_LOCKOUT_EN: count consecutive failed
// lookups and lock out further requests after MAX_FAILS; otherwise lockout=0.
//
// state | meaning
// IDLE  | waiting for req, address parked at 0
// ISSUE | stepping addresses 0..DEPTH-1, comparing returned words
// DRAIN | all addresses issued, waiting for the last reads to return
// DONE  | one-cycle done pulse, result held
module id_rom_lookup_ctrl
  import id_rom_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ROM_LATENCY = 2,
  parameter int MAX_FAILS   = 3
) (
  input logic                 clk,
  input logic                 rst,
  id_rom_lookup_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              match_q, match_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  token_t            push_tok, pop_tok;
  logic              hit;
  logic              enter_done;
  logic              locked;

  // Read token i enters at the edge that drives address i and leaves
  // ROM_LATENCY+1 edges later, exactly when rom_q holds entry i.
  rom_rd_pipe #(
    .STAGES(ROM_LATENCY + 1)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (enter_done),
    .push_tok (push_tok),
    .pop_tok  (pop_tok)
  );

  assign hit = is_hit(pop_tok, bus.rom_q, id_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    match_d  = match_q;
    idx_d    = idx_q;
    push_tok = '0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (bus.req && !locked) begin
          id_d    = bus.id_in;
          match_d = 1'b0;
          idx_d   = '0;
          state_d = ISSUE;
          // Empty candidate issues no reads; ISSUE closes it out next edge.
          if (bus.id_in != EMPTY_ID) begin
            push_tok.valid = 1'b1;
            push_tok.index = '0;
          end
        end
      end
      ISSUE: begin
        if (id_q == EMPTY_ID) begin
          state_d = DONE;
        end else if (hit) begin
          match_d = 1'b1;
          idx_d   = pop_tok.index;
          state_d = DONE;
        end else if (addr_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          addr_d         = addr_q + 1'b1;
          push_tok.valid = 1'b1;
          push_tok.index = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (hit) begin
          match_d = 1'b1;
          idx_d   = pop_tok.index;
          state_d = DONE;
        end else if (pop_tok.valid && (pop_tok.index == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      match_q <= match_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ID_ROM_LOOKUP_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              lock_q;

  always_comb begin
    fail_d = fail_q;
    if (enter_done) begin
      if (match_d)                fail_d = '0;
      else if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
    end
  end

  // Lock is raised on the same edge that raises done for the last failure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q <= '0;
      lock_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
      lock_q <= lock_q | (fail_d == FAIL_MAX);
    end
  end

  assign locked      = lock_q;
  assign bus.lockout = lock_q;
`else
  logic unused_max_fails;
  assign unused_max_fails = (MAX_FAILS != 0);
  assign locked           = 1'b0;
  assign bus.lockout      = 1'b0;
`endif

  assign bus.rom_address = addr_q;
  assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_index = idx_q;

endmodule

// File: tb/tb_id_rom_lookup_ctrl.sv
// Bench for id_rom_lookup_ctrl: 2-cycle-latency ROM model, directed lookups
// from the test plan, then randomized ROM contents and candidate IDs checked
// against a search-by-rules reference model.
module tb_id_rom_lookup_ctrl;

`ifdef ID_ROM_LOOKUP_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  id_rom_lookup_ctrl_if bus ();

  id_rom_lookup_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [8];
  logic [2:0]  rom_addr_r;
  logic [15:0] rom_q_r;

  always @(posedge clk) begin
    rom_addr_r <= bus.rom_address;
    rom_q_r    <= rom[rom_addr_r];
  end
  assign bus.rom_q = rom_q_r;

  int n_vec = 0;
  int n_err = 0;
  int fail_m = 0;
  bit locked_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected result: first nonzero entry equal to id wins; latency in edges
  // from accept to the edge that raises done.
  task automatic ref_model(input logic [15:0] id, output logic m,
                           output logic [2:0] idx, output int lat);
    m = 1'b0; idx = 3'd0; lat = 10;
    if (id == 16'h0000) begin
      lat = 1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!m && rom[i] == id && rom[i] != 16'h0000) begin
          m = 1'b1; idx = 3'(i); lat = i + 3;
        end
      end
    end
  endtask

  function automatic int exp_addr(input logic [15:0] id, input int k);
    if (id == 16'h0000) return 0;
    return (k > 7) ? 7 : k;
  endfunction

  task automatic run_lookup(input logic [15:0] id, input bit disturb);
    logic m_e;
    logic [2:0] idx_e;
    int lat_e, k, addr_bad;
    bit seen;
    ref_model(id, m_e, idx_e, lat_e);
    @(negedge clk);
    bus.req = 1'b1; bus.id_in = id;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.id_in = 16'($urandom);
    if (locked_m) begin
      k = 0;
      repeat (12) begin
        if (bus.busy || bus.done) k++;
        @(posedge clk); #1;
      end
      check("locked_ignore", k, 0);
      check("locked_flag", bus.lockout, 1);
      return;
    end
    check("busy_accept", bus.busy, 1);
    k = 0; seen = 1'b0; addr_bad = 0;
    while (!seen && k < 20) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.rom_address != 3'(exp_addr(id, k))) addr_bad++;
        if (disturb && k == 2) begin
          bus.req = 1'b1; bus.id_in = 16'($urandom);
        end
        @(posedge clk); #1;
        k++;
      end
    end
    bus.req = 1'b0;
    check("done_seen", seen, 1);
    check("latency", k, lat_e);
    check("match", bus.match, m_e);
    check("match_index", bus.match_index, idx_e);
    check("busy_at_done", bus.busy, 0);
    check("addr_seq", addr_bad, 0);
    if (m_e) fail_m = 0;
    else if (fail_m < 3) fail_m++;
    if (LOCK_EN && fail_m >= 3) locked_m = 1'b1;
    check("lockout", bus.lockout, locked_m);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("busy_after", bus.busy, 0);
    check("match_hold", bus.match, m_e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; fail_m = 0; locked_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic reset_mid_search(input logic [15:0] id, input int at_edge);
    int k;
    @(negedge clk);
    bus.req = 1'b1; bus.id_in = id;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (at_edge) @(posedge clk);
    #1 rst = 1'b0;
    fail_m = 0; locked_m = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_match", bus.match, 0);
    check("rst_index", bus.match_index, 0);
    check("rst_addr", bus.rom_address, 0);
    check("rst_lockout", bus.lockout, 0);
    k = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) k++;
    end
    check("rst_quiet", k, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] pool_pick();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h1234;
      2:       return 16'hBEEF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] id;
    rst = 1'b0; bus.req = 1'b0; bus.id_in = 16'h0000;
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h1234;
    rom[4] = 16'h0000; rom[5] = 16'h5555; rom[6] = 16'h1234; rom[7] = 16'h7777;
    #3;
    check("reset_addr", bus.rom_address, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_match", bus.match, 0);
    check("reset_index", bus.match_index, 0);
    check("reset_lockout", bus.lockout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_lookup(16'h1234, 1'b0);
    run_lookup(16'h1111, 1'b0);
    run_lookup(16'h7777, 1'b0);
    run_lookup(16'h9999, 1'b0);
    run_lookup(16'h0000, 1'b0);
    run_lookup(16'h1234, 1'b1);
    run_lookup(16'h9999, 1'b1);
    reset_mid_search(16'h9999, 4);
    run_lookup(16'h1111, 1'b0);

    apply_reset();
    run_lookup(16'h9999, 1'b0);
    run_lookup(16'h9999, 1'b0);
    run_lookup(16'h9999, 1'b0);
    run_lookup(16'h1111, 1'b0);
    apply_reset();
    run_lookup(16'h9999, 1'b0);
    run_lookup(16'h1111, 1'b0);
    run_lookup(16'h9999, 1'b0);
    run_lookup(16'h0000, 1'b0);

    for (int it = 0; it < 48; it++) begin
      if (it % 8 == 0) begin
        for (int i = 0; i < 8; i++) rom[i] = pool_pick();
        apply_reset();
      end
      case ($urandom_range(0, 3))
        0:       id = rom[$urandom_range(0, 7)];
        1:       id = 16'h0000;
        2:       id = 16'($urandom);
        default: id = 16'hBEEF;
      endcase
      if (it % 8 == 5) reset_mid_search(id, $urandom_range(1, 8));
      else             run_lookup(id, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
